// File: rtl/xocc_dsa_port.sv
// DSA-side endpoint of one xocc cmd/rsp queue pair: FIFO pop -> 1-entry request register -> core; core result -> rsp buffer -> rsp FIFO.
// Fetch-to-request 1 cycle, result-to-push 1 cycle; credits cap in-flight work so core results never see rsp-FIFO backpressure.
module xocc_dsa_port #(
  parameter int CMD_WIDTH       = 96,
  parameter int RSP_WIDTH       = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                   forever_cpuclk,
  input  logic                                   cpurst_b,
  input  logic                                   empty_cmd,
  input  logic [CMD_WIDTH-1:0]                   dsa_cmd_buffer,
  output logic                                   rd_en_cmd,
  input  logic                                   full_rsp,
  output logic                                   wr_en_rsp,
  output logic [RSP_WIDTH-1:0]                   dsa_rsp_buffer,
  output logic                                   core_req_vld,
  input  logic                                   core_req_rdy,
  output logic [CMD_WIDTH-1:0]                   core_req_data,
  input  logic                                   core_rsp_vld,
  output logic                                   core_rsp_rdy,
  input  logic [RSP_WIDTH-1:0]                   core_rsp_data,
  input  logic                                   dsa_flush,
  output logic                                   dsa_idle,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam logic [CNT_W:0]   CREDIT_MAX = (CNT_W + 1)'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  state_t               state;
  logic                 run;
  logic [RSP_WIDTH-1:0] rsp_mem [MAX_OUTSTANDING];
  logic [PTR_W:0]       wr_ptr;
  logic [PTR_W:0]       rd_ptr;
  logic                 buf_empty;
  logic                 buf_full;
  logic                 req_hs;
  logic                 rsp_hs;
  logic                 load;
  logic [CNT_W:0]       credit_use;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign buf_empty      = (wr_ptr == rd_ptr);
  assign buf_full       = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                          (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign core_rsp_rdy   = ~buf_full;
  assign rsp_hs         = core_rsp_vld & core_rsp_rdy;
  assign wr_en_rsp      = ~buf_empty & ~full_rsp;
  assign dsa_rsp_buffer = buf_empty ? '0 : rsp_mem[rd_ptr[PTR_W-1:0]];

  assign req_hs     = core_req_vld & core_req_rdy;
  // A held request already owns a credit even before the core takes it.
  assign credit_use = {1'b0, outstanding} + {{CNT_W{1'b0}}, core_req_vld};
  assign load       = run & ~empty_cmd & ~dsa_flush & (state != DRAIN) &
                      (~core_req_vld | core_req_rdy) & (credit_use < CREDIT_MAX);
  assign rd_en_cmd  = load;
  assign dsa_idle   = ~core_req_vld & (outstanding == '0) & buf_empty;

  // Keeps the FIFO untouched while reset is asserted and on the release edge.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) run <= 1'b0;
    else           run <= 1'b1;
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      core_req_vld  <= 1'b0;
      core_req_data <= '0;
    end else if (load) begin
      core_req_vld  <= 1'b1;
      core_req_data <= dsa_cmd_buffer;
    end else if (req_hs) begin
      core_req_vld  <= 1'b0;
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      outstanding <= '0;
    end else begin
      case ({req_hs, wr_en_rsp})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (rsp_hs)    wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
      if (wr_en_rsp) rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (rsp_hs) rsp_mem[wr_ptr[PTR_W-1:0]] <= core_rsp_data;
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (dsa_flush)      state <= DRAIN;
          else if (load)      state <= BUSY;
        end
        BUSY: begin
          if (dsa_flush)      state <= DRAIN;
          else if (dsa_idle)  state <= IDLE;
        end
        DRAIN: begin
          if (dsa_idle && !dsa_flush) state <= IDLE;
        end
        default:              state <= IDLE;
      endcase
    end
  end

  a_credit_overflow: assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
    !((outstanding == CNT_MAX) && req_hs && !wr_en_rsp));
  a_credit_underflow: assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
    !((outstanding == '0) && wr_en_rsp && !req_hs));
  a_rsp_into_full_buf: assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
    !(core_rsp_vld && buf_full));

endmodule

// File: tb/tb_xocc_dsa_port.sv
// Directed bench for xocc_dsa_port: queue-based command FIFO, per-cycle reference model compared on every falling edge,
// plus literal expectations at the cycles the test plan names.
module tb_xocc_dsa_port;

  localparam int MAXO = 4;

  logic        forever_cpuclk = 1'b0;
  logic        cpurst_b;
  logic        empty_cmd;
  logic [95:0] dsa_cmd_buffer;
  logic        rd_en_cmd;
  logic        full_rsp;
  logic        wr_en_rsp;
  logic [31:0] dsa_rsp_buffer;
  logic        core_req_vld;
  logic        core_req_rdy;
  logic [95:0] core_req_data;
  logic        core_rsp_vld;
  logic        core_rsp_rdy;
  logic [31:0] core_rsp_data;
  logic        dsa_flush;
  logic        dsa_idle;
  logic [2:0]  outstanding;

  xocc_dsa_port #(.CMD_WIDTH(96), .RSP_WIDTH(32), .MAX_OUTSTANDING(MAXO)) dut (
    .forever_cpuclk (forever_cpuclk),
    .cpurst_b       (cpurst_b),
    .empty_cmd      (empty_cmd),
    .dsa_cmd_buffer (dsa_cmd_buffer),
    .rd_en_cmd      (rd_en_cmd),
    .full_rsp       (full_rsp),
    .wr_en_rsp      (wr_en_rsp),
    .dsa_rsp_buffer (dsa_rsp_buffer),
    .core_req_vld   (core_req_vld),
    .core_req_rdy   (core_req_rdy),
    .core_req_data  (core_req_data),
    .core_rsp_vld   (core_rsp_vld),
    .core_rsp_rdy   (core_rsp_rdy),
    .core_rsp_data  (core_rsp_data),
    .dsa_flush      (dsa_flush),
    .dsa_idle       (dsa_idle),
    .outstanding    (outstanding)
  );

  always #5 forever_cpuclk = ~forever_cpuclk;

  int          checks = 0;
  int          errors = 0;
  int          rd_cnt = 0;
  int          rc;
  bit          pop_pend = 0;
  logic [95:0] cmd_q [$];
  logic [31:0] rsp_log [$];

  // Reference model state: held request, credits in use, collected responses, drain mode.
  bit          m_vld = 0;
  logic [95:0] m_data = '0;
  int          m_out = 0;
  logic [31:0] rspq [$];
  bit          m_drain = 0;
  bit          m_run = 0;
  bit          e_idle, e_load, e_rrdy, e_wr, req_hs, rsp_hs;
  logic [31:0] e_buf;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic refresh();
    empty_cmd      = (cmd_q.size() == 0);
    dsa_cmd_buffer = (cmd_q.size() == 0) ? 96'd0 : cmd_q[0];
  endtask

  task automatic push(input logic [95:0] c);
    cmd_q.push_back(c);
    refresh();
  endtask

  task automatic tick();
    @(posedge forever_cpuclk);
    #1;
    if (pop_pend) begin
      if (cmd_q.size() > 0) void'(cmd_q.pop_front());
      pop_pend = 0;
    end
    refresh();
  endtask

  task automatic respond(input logic [31:0] d);
    core_rsp_vld  = 1'b1;
    core_rsp_data = d;
    tick();
    core_rsp_vld  = 1'b0;
  endtask

  function automatic logic [95:0] mk(input int i);
    return {32'hA000_0000 + 32'(i), 32'h5555_0000 + 32'(i), 32'(i)};
  endfunction

  always @(negedge forever_cpuclk) begin
    if (!cpurst_b) begin
      m_vld = 0; m_data = '0; m_out = 0; rspq.delete(); m_drain = 0; m_run = 0; pop_pend = 0;
    end else begin
      e_idle = !m_vld && (m_out == 0) && (rspq.size() == 0);
      e_load = m_run && (cmd_q.size() != 0) && !dsa_flush && !m_drain &&
               (!m_vld || core_req_rdy) && (m_out + int'(m_vld) < MAXO);
      e_rrdy = rspq.size() < MAXO;
      e_wr   = (rspq.size() != 0) && !full_rsp;
      e_buf  = (rspq.size() != 0) ? rspq[0] : 32'd0;
      chk("m_rd_en_cmd", rd_en_cmd, e_load);
      chk("m_core_req_vld", core_req_vld, m_vld);
      if (m_vld) chk("m_core_req_data", core_req_data, m_data);
      chk("m_outstanding", outstanding, m_out);
      chk("m_wr_en_rsp", wr_en_rsp, e_wr);
      chk("m_dsa_rsp_buffer", dsa_rsp_buffer, e_buf);
      chk("m_core_rsp_rdy", core_rsp_rdy, e_rrdy);
      chk("m_dsa_idle", dsa_idle, e_idle);
      req_hs = m_vld && core_req_rdy;
      rsp_hs = core_rsp_vld && e_rrdy;
      m_out  = m_out + int'(req_hs) - int'(e_wr);
      if (e_wr)   void'(rspq.pop_front());
      if (rsp_hs) rspq.push_back(core_rsp_data);
      m_drain = dsa_flush ? 1'b1 : (m_drain && !e_idle);
      if (e_load) begin
        m_vld  = 1;
        m_data = cmd_q[0];
      end else if (req_hs) begin
        m_vld = 0;
      end
      m_run    = 1;
      pop_pend = rd_en_cmd;
      if (rd_en_cmd) rd_cnt++;
      if (wr_en_rsp) rsp_log.push_back(dsa_rsp_buffer);
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_core_req_vld"}, core_req_vld, 0);
    chk({tag, "_core_req_data"}, core_req_data, 0);
    chk({tag, "_outstanding"}, outstanding, 0);
    chk({tag, "_wr_en_rsp"}, wr_en_rsp, 0);
    chk({tag, "_dsa_rsp_buffer"}, dsa_rsp_buffer, 0);
    chk({tag, "_rd_en_cmd"}, rd_en_cmd, 0);
    chk({tag, "_core_rsp_rdy"}, core_rsp_rdy, 1);
    chk({tag, "_dsa_idle"}, dsa_idle, 1);
  endtask

  initial begin
    cpurst_b = 1'b0; full_rsp = 1'b0; core_req_rdy = 1'b1;
    core_rsp_vld = 1'b0; core_rsp_data = '0; dsa_flush = 1'b0;
    refresh();
    #2;
    chk_reset_vals("rst");
    repeat (2) tick();
    cpurst_b = 1'b1;
    repeat (2) tick();

    // Single command round trip.
    rsp_log.delete();
    push(96'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA);
    #1 chk("single_rd_en_c0", rd_en_cmd, 1);
    tick(); #1;
    chk("single_vld_c1", core_req_vld, 1);
    chk("single_data_c1", core_req_data, 96'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA);
    chk("single_rd_en_c1", rd_en_cmd, 0);
    tick(); #1 chk("single_out_c2", outstanding, 1);
    tick();
    tick(); core_rsp_vld = 1'b1; core_rsp_data = 32'h5A5A;
    tick(); core_rsp_vld = 1'b0; #1;
    chk("single_wr_en_c5", wr_en_rsp, 1);
    chk("single_rsp_c5", dsa_rsp_buffer, 32'h5A5A);
    tick(); #1;
    chk("single_out_c6", outstanding, 0);
    chk("single_idle_c6", dsa_idle, 1);

    // Credit limit: six queued, core never answers.
    rd_cnt = 0;
    for (int i = 0; i < 6; i++) push(mk(i));
    repeat (10) tick(); #1;
    chk("credit_pulses", rd_cnt, 4);
    chk("credit_out", outstanding, 4);
    chk("credit_rd_en", rd_en_cmd, 0);
    chk("credit_left", cmd_q.size(), 2);

    // Response FIFO backpressure with a full buffer.
    full_rsp = 1'b1;
    for (int i = 0; i < 4; i++) begin
      core_rsp_vld = 1'b1; core_rsp_data = 32'hC000_0000 + 32'(i);
      #1 chk("bp_wr_en", wr_en_rsp, 0);
      tick();
    end
    core_rsp_vld = 1'b0;
    #1;
    chk("bp_rsp_rdy", core_rsp_rdy, 0);
    chk("bp_out", outstanding, 4);
    push(mk(6)); push(mk(7));
    repeat (2) tick(); #1;
    chk("bp_no_fetch", rd_cnt, 4);
    rsp_log.delete();
    full_rsp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_release_wr", wr_en_rsp, 1);
      chk("bp_release_order", dsa_rsp_buffer, 32'hC000_0000 + 32'(i));
      tick();
    end
    repeat (6) tick(); #1;
    chk("bp_resume_fetch", rd_cnt, 8);
    chk("bp_resume_out", outstanding, 4);
    chk("bp_log_size", rsp_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("bp_log_entry", rsp_log[i], 32'hC000_0000 + 32'(i));
    for (int i = 0; i < 4; i++) respond(32'hD000_0000 + 32'(i));
    repeat (4) tick(); #1 chk("bp_idle", dsa_idle, 1);

    // Core stall with a held request, then back-to-back reload.
    core_req_rdy = 1'b0;
    push(mk(20)); push(mk(21)); push(mk(22));
    #1 chk("stall_first_load", rd_en_cmd, 1);
    for (int i = 1; i <= 5; i++) begin
      tick(); #1;
      chk("stall_rd_en", rd_en_cmd, 0);
      chk("stall_vld", core_req_vld, 1);
      chk("stall_data", core_req_data, mk(20));
    end
    tick(); core_req_rdy = 1'b1; #1;
    chk("stall_b2b_load", rd_en_cmd, 1);
    chk("stall_hs_data", core_req_data, mk(20));
    tick(); #1;
    chk("stall_next_vld", core_req_vld, 1);
    chk("stall_next_data", core_req_data, mk(21));
    repeat (4) tick();
    for (int i = 0; i < 3; i++) respond(32'hB000_0000 + 32'(i));
    repeat (4) tick(); #1 chk("stall_idle", dsa_idle, 1);

    // Flush with two outstanding and three queued.
    push(mk(30)); push(mk(31));
    repeat (5) tick(); #1 chk("flush_pre_out", outstanding, 2);
    dsa_flush = 1'b1;
    push(mk(40)); push(mk(41)); push(mk(42));
    rc = rd_cnt;
    #1 chk("flush_rd_en", rd_en_cmd, 0);
    repeat (3) begin tick(); #1 chk("flush_rd_en", rd_en_cmd, 0); end
    rsp_log.delete();
    respond(32'hF000_0000); respond(32'hF000_0001);
    repeat (3) tick(); #1;
    chk("flush_idle", dsa_idle, 1);
    chk("flush_log_size", rsp_log.size(), 2);
    chk("flush_log0", rsp_log[0], 32'hF000_0000);
    chk("flush_log1", rsp_log[1], 32'hF000_0001);
    chk("flush_fifo_kept", cmd_q.size(), 3);
    repeat (3) begin tick(); #1 chk("drain_hold_rd_en", rd_en_cmd, 0); end
    tick(); dsa_flush = 1'b0; #1 chk("drain_exit_rd_en", rd_en_cmd, 0);
    chk("drain_no_fetch", rd_cnt, rc);
    tick(); #1 chk("drain_resume_rd_en", rd_en_cmd, 1);

    // Asynchronous reset with three outstanding and a buffered response.
    repeat (6) tick(); #1 chk("arst_pre_out", outstanding, 3);
    full_rsp = 1'b1;
    respond(32'hE000_0000);
    #1;
    chk("arst_pre_buf", dsa_rsp_buffer, 32'hE000_0000);
    chk("arst_pre_wr", wr_en_rsp, 0);
    #1;
    cpurst_b = 1'b0;
    cmd_q.delete();
    refresh();
    #1 chk_reset_vals("arst");
    repeat (2) tick();
    cpurst_b = 1'b1; full_rsp = 1'b0;
    repeat (2) tick();
    push(mk(50));
    repeat (3) tick(); #1 chk("post_rst_out", outstanding, 1);
    respond(32'h6006);
    repeat (3) tick(); #1;
    chk("post_rst_idle", dsa_idle, 1);
    chk("post_rst_rsp", rsp_log[rsp_log.size()-1], 32'h6006);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
